// File: rtl/product_accumulator_pkg.sv
// prod_acc_pkg: shared state encoding and width defaults for product_accumulator
package prod_acc_pkg;
  localparam int PW_DEF = 64;
  localparam int CW_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: batch control, product stream and result handshake
interface product_accumulator_if #(
  parameter int PW = prod_acc_pkg::PW_DEF,
  parameter int CW = prod_acc_pkg::CW_DEF
);
  logic                 start;
  logic [CW-1:0]        len;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_prod;
  logic                 in_ovf;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW-1:0] out_acc;
  logic                 out_ovf;
  logic                 busy;
  modport master (
    output start, len, in_valid, in_prod, in_ovf, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );
  modport slave (
    input  start, len, in_valid, in_prod, in_ovf, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );
endinterface

// File: rtl/product_accumulator_sat_add.sv
// sat_add: signed adder with overflow flag; clamps to the signed range when ACC_SATURATE_EN is defined
module sat_add #(
  parameter int PW = prod_acc_pkg::PW_DEF
) (
  input  logic signed [PW-1:0] a,
  input  logic signed [PW-1:0] b,
  output logic signed [PW-1:0] sum,
  output logic                 ovf
);
  logic signed [PW-1:0] raw;
  assign raw = a + b;
  assign ovf = (a[PW-1] == b[PW-1]) && (raw[PW-1] != a[PW-1]);
`ifdef ACC_SATURATE_EN
  // both operands share a sign on overflow, so a's sign picks the rail
  assign sum = ovf ? (a[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}}) : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a batch of len signed products with sticky overflow; ACC_SATURATE_EN selects clamping
module product_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input logic clk,
  input logic rst,
  product_accumulator_if.slave bus
);
  state_t               state;
  logic [CW-1:0]        len_r;
  logic [CW-1:0]        count;
  logic signed [PW-1:0] acc;
  logic signed [PW-1:0] sum;
  logic                 add_ovf;
  logic                 ovf;
  sat_add #(.PW(PW)) u_add (
    .a  (acc),
    .b  (bus.in_prod),
    .sum(sum),
    .ovf(add_ovf)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len_r <= '0;
      count <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          len_r <= bus.len;
          count <= '0;
          acc   <= '0;
          ovf   <= 1'b0;
          state <= (bus.len == '0) ? DONE : ACC;
        end
        ACC: if (bus.in_valid) begin
          acc   <= sum;
          ovf   <= ovf | add_ovf | bus.in_ovf;
          count <= count + CW'(1);
          if (count == len_r - CW'(1)) state <= DONE;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_acc   = acc;
  assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: randomized batches checked every cycle against a wide-arithmetic model
module tb_product_accumulator;
  localparam int PW = 64;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int m_phase = 0;
  int m_left = 0;
  logic [63:0] m_acc = '0;
  logic m_ovf = 1'b0;
  logic [63:0] got_acc;
  logic got_ovf;
  product_accumulator_if #(.PW(PW), .CW(CW)) bus ();
  product_accumulator #(.PW(PW), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [64:0] wide(input logic [63:0] a, input logic [63:0] b);
    return {a[63], a} + {b[63], b};
  endfunction
  function automatic logic [63:0] fold(input logic [64:0] w);
    if (w[64] == w[63]) return w[63:0];
`ifdef ACC_SATURATE_EN
    return w[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`else
    return w[63:0];
`endif
  endfunction
  // reference: phase 0 idle, 1 collecting, 2 holding the result
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_acc   <= '0;
      m_ovf   <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.start) begin
        m_acc   <= '0;
        m_ovf   <= 1'b0;
        m_left  <= int'(bus.len);
        m_phase <= (bus.len == '0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (bus.in_valid) begin
        m_acc  <= fold(wide(m_acc, bus.in_prod));
        m_ovf  <= m_ovf | bus.in_ovf | (wide(m_acc, bus.in_prod) > 65'h0_7FFF_FFFF_FFFF_FFFF &&
                  wide(m_acc, bus.in_prod) < 65'h1_8000_0000_0000_0000);
        m_left <= m_left - 1;
        if (m_left == 1) m_phase <= 2;
      end
    end else if (bus.out_ready) begin
      m_phase <= 0;
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_phase == 1));
      chk("out_valid", 64'(bus.out_valid), 64'(m_phase == 2));
      chk("busy", 64'(bus.busy), 64'(m_phase != 0));
      if (m_phase == 2) begin
        chk("out_acc", bus.out_acc, m_acc);
        chk("out_ovf", 64'(bus.out_ovf), 64'(m_ovf));
      end
    end
  end
  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 3))
      0: return 64'(signed'(int'($urandom_range(0, 2000)) - 1000));
      1: return {$urandom, $urandom};
      2: return {32'h7FFF_FFFF, $urandom};
      default: return {32'h8000_0000, $urandom};
    endcase
  endfunction
  task automatic do_start(input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len = CW'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.len = CW'($urandom);
  endtask
  task automatic feed(input logic [63:0] p, input bit o, input int gap);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_prod = rand64();
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_prod = p;
    bus.in_ovf = o;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_ovf = 1'b0;
  endtask
  task automatic finish_batch(input int stall, output logic [63:0] a, output logic o);
    chk("valid_latency", 64'(bus.out_valid), 64'd1);
    a = bus.out_acc;
    o = bus.out_ovf;
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_after_done", 64'(bus.busy), 64'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_prod = '0;
    bus.in_ovf = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_acc", bus.out_acc, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    do_start(3);
    feed(64'd5, 1'b0, 0);
    feed(-64'sd7, 1'b0, 0);
    feed(64'd100, 1'b0, 0);
    finish_batch(0, got_acc, got_ovf);
    chk("basic_acc", got_acc, 64'd98);
    chk("basic_ovf", 64'(got_ovf), 64'd0);
    do_start(0);
    finish_batch(0, got_acc, got_ovf);
    chk("zero_len_acc", got_acc, 64'd0);
    chk("zero_len_ovf", 64'(got_ovf), 64'd0);
    do_start(2);
    feed(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 0);
    feed(64'd1, 1'b0, 0);
    finish_batch(1, got_acc, got_ovf);
`ifdef ACC_SATURATE_EN
    chk("pos_ovf_acc", got_acc, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    chk("pos_ovf_acc", got_acc, 64'h8000_0000_0000_0000);
`endif
    chk("pos_ovf_flag", 64'(got_ovf), 64'd1);
    do_start(4);
    feed(64'd1000, 1'b0, 2);
    feed(-64'sd250, 1'b0, 1);
    feed(64'd33, 1'b0, 3);
    feed(-64'sd1, 1'b0, 1);
    finish_batch(5, got_acc, got_ovf);
    chk("gaps_acc", got_acc, 64'd782);
    chk("gaps_ovf", 64'(got_ovf), 64'd0);
    do_start(3);
    feed(64'd11, 1'b0, 0);
    feed(64'd22, 1'b0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_acc", bus.out_acc, 64'd0);
    chk("midrst_out_ovf", 64'(bus.out_ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_start(1);
    feed(-64'sd9, 1'b0, 0);
    finish_batch(0, got_acc, got_ovf);
    chk("after_rst_acc", got_acc, 64'hFFFF_FFFF_FFFF_FFF7);
    do_start(2);
    bus.start = 1'b1;
    bus.len = '0;
    @(negedge clk);
    bus.start = 1'b0;
    feed(64'd10, 1'b0, 0);
    feed(64'd20, 1'b1, 1);
    finish_batch(0, got_acc, got_ovf);
    chk("in_ovf_acc", got_acc, 64'd30);
    chk("in_ovf_flag", 64'(got_ovf), 64'd1);
    for (int b = 0; b < 40; b++) begin
      int n;
      n = $urandom_range(0, 6);
      do_start(n);
      for (int i = 0; i < n; i++) feed(rand64(), $urandom_range(0, 7) == 0, $urandom_range(0, 2));
      finish_batch($urandom_range(0, 3), got_acc, got_ovf);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PW, default 64: product and accumulator width in bits, two's complement.
REQ-002 SHALL have parameter CW, default 8: batch-length counter width in bits.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  begin a batch; honoured only in IDLE.
REQ-007 len  input  CW  number of products in the batch, sampled on accepted start.
REQ-008 in_valid  input  1  upstream multiplier product valid.
REQ-009 in_ready  output  1  block accepts a product this cycle.
REQ-010 in_prod  input  PW  signed product from the upstream Booth multiplier.
REQ-011 in_ovf  input  1  upstream multiplier overflow flag for in_prod.
REQ-012 out_valid  output  1  batch result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_acc  output  PW  signed accumulated sum.
REQ-015 out_ovf  output  1  sticky overflow for the batch.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, ACC, DONE.
REQ-018 IDLE: start=1 -> latch len, clear acc, count and ovf; next ACC if len!=0, DONE if len==0 (out_acc=0, out_ovf=0).
REQ-019 ACC: in_ready=1; transfer when in_valid&in_ready; acc <= acc + in_prod (signed, PW bits), count increments.
REQ-020 Transfer with count==len-1 SHALL move to DONE next cycle; acc then includes that product.
REQ-021 ACC with in_valid=0 SHALL hold acc, count and state indefinitely.
REQ-022 DONE: out_valid=1, out_acc/out_ovf stable until out_valid&out_ready, then IDLE next cycle.
REQ-023 in_ready SHALL be 0 in IDLE and DONE; out_valid SHALL be 0 in IDLE and ACC.
REQ-024 start outside IDLE SHALL be ignored; len changes outside the accepting cycle SHALL be ignored.
REQ-025 Signed add overflow (operand signs equal, sum sign differs) OR in_ovf on a transfer SHALL set ovf sticky for the batch.
REQ-026 Latency: one product per cycle; out_valid asserts the cycle after the last transfer; zero-len batch asserts out_valid the cycle after start.
REQ-027 out_acc SHALL reflect the acc register directly (registered output, no combinational path from in_prod).

Reset
REQ-028 rst=1 at any time, including mid-batch or mid-DONE, SHALL immediately force IDLE, acc=0, count=0, ovf=0, in_ready=0, out_valid=0, busy=0; partial batch discarded.
REQ-029 First start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro ACC_SATURATE_EN defined: on add overflow acc SHALL clamp to 2^(PW-1)-1 (positive overflow) or -2^(PW-1) (negative) and stay clamped-accumulating from that value.
REQ-031 Macro ACC_SATURATE_EN undefined: acc SHALL wrap modulo 2^PW; out_ovf behaviour identical in both builds.

Structure
REQ-032 Package prod_acc_pkg SHALL hold the state enum (IDLE, ACC, DONE) and width defaults PW, CW.
REQ-033 Sub-module sat_add SHALL compute sum and overflow flag, with clamp logic under ACC_SATURATE_EN.

Verification
REQ-034 len=3, products 5, -7, 100, in_valid continuous -> out_acc=98, out_ovf=0, out_valid 1 cycle after third transfer.
REQ-035 len=0, start -> out_valid next cycle, out_acc=0, out_ovf=0; out_ready=1 -> IDLE.
REQ-036 len=2, products 0x7FFF_FFFF_FFFF_FFFF then 1 -> out_ovf=1; out_acc=0x8000_0000_0000_0000 (wrap) or 0x7FFF_FFFF_FFFF_FFFF (ACC_SATURATE_EN).
REQ-037 len=4, in_valid toggling with gaps, out_ready held low 5 cycles in DONE -> sum correct, out_acc stable throughout stall.
REQ-038 len=3, rst pulsed after second transfer -> all outputs 0, IDLE; new batch len=1, product -9 -> out_acc=-9.
REQ-039 len=2, second product with in_ovf=1, sum in range -> out_ovf=1; start asserted during ACC ignored.
